// File: rtl/frost_pkg.sv
// Shared core constants: data width, register address width and the opcodes
// the control unit decodes.
package frost_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OP_IMM = 7'b0010011;

endpackage

// File: rtl/reg_file.sv
// Register file: NREGS x XLEN, two registered read ports, one write port.
// After reset the array is zeroed one entry per cycle before strobes are honoured.
module reg_file #(
  parameter int unsigned XLEN  = frost_pkg::XLEN,
  parameter int unsigned NREGS = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        re1,
  input  logic                        re2,
  input  logic [frost_pkg::REG_AW-1:0] rs1,
  input  logic [frost_pkg::REG_AW-1:0] rs2,
  input  logic                        we,
  input  logic [frost_pkg::REG_AW-1:0] rd,
  input  logic [XLEN-1:0]             wd,
  output logic [XLEN-1:0]             rd1,
  output logic [XLEN-1:0]             rd2,
  output logic                        ready
);

  localparam int unsigned AW = frost_pkg::REG_AW;
  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] rd1_q, rd1_d;
  logic [XLEN-1:0] rd2_q, rd2_d;

  logic [XLEN-1:0] mem [NREGS];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic            user_wr;
  logic [XLEN-1:0] rdata1, rdata2;

  // A real write only lands in RUN and never targets x0.
  assign user_wr = (state_q == StRun) && we && (rd != '0);

  // Read data with x0 forced to zero and write-first bypass per port.
  always_comb begin
    rdata1 = mem[rs1];
    rdata2 = mem[rs2];
    if (user_wr && (rd == rs1)) rdata1 = wd;
    if (user_wr && (rd == rs2)) rdata2 = wd;
    if (rs1 == '0) rdata1 = '0;
    if (rs2 == '0) rdata2 = '0;
  end

  // Next-state: reset restarts the clear sweep; RUN serves strobes.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ready_d   = ready_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    mem_we    = 1'b0;
    mem_waddr = rd;
    mem_wdata = wd;
    if (reset) begin
      state_d = StClear;
      ptr_d   = '0;
      ready_d = 1'b0;
      rd1_d   = '0;
      rd2_d   = '0;
    end else begin
      unique case (state_q)
        StClear: begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = '0;
          ptr_d     = ptr_q + AW'(1);
          rd1_d     = '0;
          rd2_d     = '0;
          if (ptr_q == LastIdx) begin
            state_d = StRun;
            ready_d = 1'b1;
            ptr_d   = '0;
          end
        end
        StRun: begin
          mem_we = user_wr;
          if (re1) rd1_d = rdata1;
          if (re2) rd2_d = rdata2;
        end
        default: state_d = StClear;
      endcase
    end
  end

  // Control and output registers, synchronous reset handled in next-state logic.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
    ready_q <= ready_d;
    rd1_q   <= rd1_d;
    rd2_q   <= rd2_d;
  end

  // Storage array; no reset so it infers as plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd1   = rd1_q;
  assign rd2   = rd2_q;
  assign ready = ready_q;

endmodule
